// File: rtl/ppu_chr_arb.sv
// ppu_chr_arb
// Arbitrates NCH requesters onto a single asynchronous-style SRAM port.
// Channel 0 is the PPU render fetch. While i_render is high it is the only
// channel that can win.
//
// Ports:
//   i_ppu_clk, i_ppu_rst        clock and synchronous active-high reset
//   i_render                    render window; masks channels 1..NCH-1
//   i_req/i_we/i_addr/i_wdata/i_be  per-channel request bundle, held until o_gnt
//   o_gnt                       one-hot grant, combinational from this cycle's requests
//   o_rvalid/o_rdata            registered read return, routed by a tag pipeline
//   o_sram_*                    registered SRAM pins (active-low strobes)
//   i_sram_rdata                SRAM read data, sampled RD_LAT cycles after drive
module ppu_chr_arb #(
    parameter int NCH      = 2,
    parameter int AW       = 12,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic                  i_ppu_clk,
    input  logic                  i_ppu_rst,
    input  logic                  i_render,
    input  logic [NCH-1:0]        i_req,
    input  logic [NCH-1:0]        i_we,
    input  logic [NCH*AW-1:0]     i_addr,
    input  logic [NCH*DW-1:0]     i_wdata,
    input  logic [NCH*DW/8-1:0]   i_be,
    output logic [NCH-1:0]        o_gnt,
    output logic [NCH-1:0]        o_rvalid,
    output logic [DW-1:0]         o_rdata,
    output logic [AW-1:0]         o_sram_addr,
    output logic [DW-1:0]         o_sram_wdata,
    input  logic [DW-1:0]         i_sram_rdata,
    output logic                  o_sram_we_n,
    output logic                  o_sram_oe_n,
    output logic [DW/8-1:0]       o_sram_be_n
);

    localparam int NBE = DW / 8;
    localparam int PW  = (NCH > 2) ? 2 : 1;

    logic [NCH-1:0] elig_s;
    logic [NCH-1:0] gnt_s;
    logic [PW-1:0]  gnt_idx_s;
    logic [PW-1:0]  start_s;
    logic [PW-1:0]  cand_s;
    logic [PW-1:0]  nxt_ptr_s;
    logic           found_s;
    logic           has_gnt_s;
    logic           gnt_we_s;
    int             cand_v;

    logic [PW-1:0]     rr_ptr_r;
    logic [RD_LAT-1:0] tag_v_r;
    logic [PW-1:0]     tag_idx_r [RD_LAT];

    // Decode a channel index into a one-hot channel vector.
    function automatic logic [NCH-1:0] idx_onehot(input logic [PW-1:0] idx);
        logic [NCH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Eligibility: nothing during reset, only ch0 inside the render window.
    always_comb begin
        elig_s = '0;
        if (i_ppu_rst) begin
            elig_s = '0;
        end else if (i_render) begin
            elig_s = i_req & {{(NCH-1){1'b0}}, 1'b1};
        end else begin
            elig_s = i_req;
        end
    end

    // Rotating search; fixed priority simply always starts at channel 0.
    // rr_ptr only moves on a real grant, so render masking leaves it alone.
    always_comb begin
        start_s   = (ARB_MODE == 1) ? rr_ptr_r : {PW{1'b0}};
        gnt_s     = '0;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        cand_v    = 0;
        cand_s    = '0;
        for (int i = 0; i < NCH; i++) begin
            cand_v = int'(start_s) + i;
            cand_v = (cand_v >= NCH) ? (cand_v - NCH) : cand_v;
            cand_s = PW'(cand_v);
            if (!found_s && elig_s[cand_s]) begin
                gnt_s[cand_s] = 1'b1;
                gnt_idx_s     = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        has_gnt_s = found_s;
        gnt_we_s  = i_we[gnt_idx_s];
        nxt_ptr_s = (gnt_idx_s == PW'(NCH - 1)) ? {PW{1'b0}} : (gnt_idx_s + {{(PW-1){1'b0}}, 1'b1});
    end

    assign o_gnt = gnt_s;

    // Round-robin pointer advances past the channel just granted.
    always_ff @(posedge i_ppu_clk) begin
        if (i_ppu_rst) begin
            rr_ptr_r <= '0;
        end else if (has_gnt_s) begin
            rr_ptr_r <= nxt_ptr_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // SRAM pin registers: one access cycle per grant, strobes idle otherwise.
    always_ff @(posedge i_ppu_clk) begin
        if (i_ppu_rst) begin
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_we_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_be_n  <= '1;
        end else if (has_gnt_s) begin
            o_sram_addr  <= i_addr[gnt_idx_s*AW +: AW];
            o_sram_wdata <= i_wdata[gnt_idx_s*DW +: DW];
            o_sram_we_n  <= ~gnt_we_s;
            o_sram_oe_n  <= gnt_we_s;
            // Reads enable every lane; writes use the requester's byte mask.
            o_sram_be_n  <= gnt_we_s ? ~i_be[gnt_idx_s*NBE +: NBE] : {NBE{1'b0}};
        end else begin
            o_sram_we_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_be_n  <= '1;
        end
    end

    // Read tag pipeline: stage 0 is the SRAM drive cycle, last stage is the sample cycle.
    always_ff @(posedge i_ppu_clk) begin
        if (i_ppu_rst) begin
            tag_v_r <= '0;
            for (int j = 0; j < RD_LAT; j++) begin
                tag_idx_r[j] <= '0;
            end
        end else begin
            tag_v_r[0]   <= has_gnt_s & ~gnt_we_s;
            tag_idx_r[0] <= gnt_idx_s;
            for (int j = 1; j < RD_LAT; j++) begin
                tag_v_r[j]   <= tag_v_r[j-1];
                tag_idx_r[j] <= tag_idx_r[j-1];
            end
        end
    end

    // Read return: capture SRAM data and pulse rvalid for the tagged channel.
    always_ff @(posedge i_ppu_clk) begin
        if (i_ppu_rst) begin
            o_rdata  <= '0;
            o_rvalid <= '0;
        end else if (tag_v_r[RD_LAT-1]) begin
            o_rdata  <= i_sram_rdata;
            o_rvalid <= idx_onehot(tag_idx_r[RD_LAT-1]);
        end else begin
            o_rdata  <= o_rdata;
            o_rvalid <= '0;
        end
    end

endmodule

// File: doc/ppu_chr_arb.md
PPU_CHR_ARB -- requirements
Module: ppu_chr_arb

Parameters
REQ-001 NCH, default 2, number of requesting channels (2..4); ch0 is the PPU render fetch.
REQ-002 AW, default 12, SRAM word-address width.
REQ-003 DW, default 16, SRAM data width (multiple of 8); NBE = DW/8 byte lanes.
REQ-004 RD_LAT, default 1, cycles from SRAM drive to data sampled from i_sram_rdata (1..3).
REQ-005 ARB_MODE, default 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Interface
REQ-006 The block SHALL use one clock, i_ppu_clk, and a synchronous active-high reset, i_ppu_rst.
REQ-007 i_ppu_clk  in  1  clock.
REQ-008 i_ppu_rst  in  1  synchronous active-high reset.
REQ-009 i_render  in  1  render window; when 1, only ch0 may be granted.
REQ-010 i_req  in  NCH  per-channel request.
REQ-011 i_we  in  NCH  per-channel write (1) / read (0).
REQ-012 i_addr  in  NCH*AW  per-channel word address, ch n at [n*AW +: AW].
REQ-013 i_wdata  in  NCH*DW  per-channel write data.
REQ-014 i_be  in  NCH*NBE  per-channel byte enables, active-high.
REQ-015 o_gnt  out  NCH  one-hot grant, combinational from current-cycle requests.
REQ-016 o_rvalid  out  NCH  one-cycle read-data-valid pulse to the owning channel.
REQ-017 o_rdata  out  DW  registered read data, shared by all channels.
REQ-018 o_sram_addr  out  AW; o_sram_wdata  out  DW; i_sram_rdata  in  DW.
REQ-019 o_sram_we_n, o_sram_oe_n  out  1; o_sram_be_n  out  NBE; all active-low.

Function
REQ-020 At most one o_gnt bit SHALL be high per cycle; a grant only goes to a channel with i_req high.
REQ-021 Handshake: a requester SHALL hold req/we/addr/wdata/be stable until o_gnt; a transfer occurs in every cycle where req & gnt are both high; back-to-back grants to the same channel are allowed.
REQ-022 ARB_MODE 0: grant the lowest-index eligible requester.
REQ-023 ARB_MODE 1: search starts at rr_ptr; after a grant to ch k, rr_ptr becomes (k+1) mod NCH; rr_ptr holds when nothing is granted.
REQ-024 When i_render=1, channels 1..NCH-1 SHALL NOT be granted and stall with req held; rr_ptr is unaffected by the masking.
REQ-025 The granted transfer SHALL drive SRAM pins from registers in the cycle after grant (cycle T+1): addr, wdata, and be_n = ~be.
REQ-026 Write: we_n=0 and oe_n=1 for exactly cycle T+1.
REQ-027 Read: oe_n=0, we_n=1 and be_n=0 (all lanes) in cycle T+1.
REQ-028 Idle: we_n=1, oe_n=1, be_n all 1; addr and wdata hold their last values.
REQ-029 Read data: sample i_sram_rdata at the end of cycle T+RD_LAT, then present it on o_rdata with o_rvalid[k] high in cycle T+RD_LAT+1; o_rdata holds until the next rvalid.
REQ-030 Channel tag: a valid+index shift pipeline of depth RD_LAT SHALL route rvalid; reads issued back-to-back SHALL return in issue order, one per cycle.
REQ-031 No data forwarding: a read granted after a write to the same address returns the written data, because SRAM accesses are strictly serial.
REQ-032 Writes SHALL NOT produce rvalid.
REQ-033 A request arriving in the same cycle that i_render rises is masked; when i_render falls, masked requests are eligible that same cycle.

Reset
REQ-034 While i_ppu_rst=1: o_gnt=0, o_rvalid=0, o_rdata=0, o_sram_addr=0, o_sram_wdata=0, we_n=1, oe_n=1, be_n all 1, rr_ptr=0, tag pipeline cleared.
REQ-035 Reset asserted with reads in flight SHALL drop them; no rvalid is emitted for those reads after reset releases.
REQ-036 Grants SHALL NOT be issued in any cycle where i_ppu_rst=1.

Verification (NCH=2, AW=12, DW=16, RD_LAT=1 unless noted)
REQ-037 Memory written at 0x123 = 0xBEEF; ch0 reads 0x123 -> gnt[0] at T, oe_n=0 and addr=0x123 at T+1, rvalid[0] with rdata=0xBEEF at T+2.
REQ-038 ch1 write 0x045 = 0x00AA with be=01 -> we_n=0, be_n=10 at T+1; subsequent read of 0x045 returns low byte 0xAA and the upper byte unchanged.
REQ-039 ARB_MODE=1 with ch0 and ch1 requesting continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; with ARB_MODE=0 -> ch0 wins all 6 cycles.
REQ-040 i_render=1 with ch1 requesting for 10 cycles -> gnt[1]=0 throughout; i_render falls -> gnt[1]=1 in the same cycle.
REQ-041 RD_LAT=3, reads ch0,ch1,ch0 back-to-back -> rvalid[0],[1],[0] in consecutive cycles T+4..T+6 with matching data.
REQ-042 Reset pulsed one cycle after a read grant -> no rvalid follows, and all SRAM strobes are inactive (we_n=1, oe_n=1, be_n all 1) on the cycle after reset.
